core_if_stage: RTL and testbench
================================

# core_if_stage

Instruction fetch stage of the RV32I core. It holds the program counter and issues word reads to instruction memory over a request/grant/rvalid port. Returned words are buffered in a small in-order FIFO and presented to the decode stage, together with their PC, over a valid/ready handshake. It is the producer of the 32-bit instruction word consumed by the ID stage, and it handles control-flow redirects by flushing in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2: instruction buffer entries; power of two, ≥2; also the maximum number of outstanding memory reads.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- o_imem_req  out  1  read request.
- o_imem_addr  out  32  word-aligned read address.
- i_imem_gnt  in  1  request accepted this cycle; a fetch is issued when req && gnt.
- i_imem_rvalid  in  1  read data valid; responses return in order, at least 1 cycle after grant.
- i_imem_rdata  in  32  read data.
- i_redirect  in  1  flush and restart fetch (branch/JALR/exception from later stages).
- i_redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.
- o_instr_valid  out  1  o_instr/o_instr_pc are valid.
- i_instr_ready  in  1  decode accepts; transfer when valid && ready.
- o_instr  out  32  instruction word (FIFO head).
- o_instr_pc  out  32  PC of o_instr.

## Operation
- State: fetch_pc, FIFO (instr, pc per entry), pc tag queue of outstanding reads, outstanding count, discard count.
- Credit: o_imem_req = !rst && !i_redirect && (fifo_count + outstanding) < FIFO_DEPTH. o_imem_addr = fetch_pc.
- On req && gnt: the issued PC is pushed to the tag queue, outstanding += 1, and fetch_pc += 4. fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- On rvalid: if discard > 0, the data is dropped and discard -= 1. Otherwise {rdata, tag} is pushed to the FIFO. In both cases outstanding -= 1. A push is guaranteed to have room by the credit rule.
- Pop on o_instr_valid && i_instr_ready. A simultaneous push and pop is allowed at any occupancy, including full.
- Redirect (i_redirect=1), registered at the clock edge:
  - The FIFO is cleared.
  - fetch_pc := {i_redirect_pc[31:2], 2'b00}.
  - discard := outstanding minus any response accepted in this same cycle; every read still in flight is dropped.
  - No request is issued in the redirect cycle.
  - A handshake to decode in the redirect cycle still completes; decode owns squashing it.
- Reset: FIFO, outstanding and discard are cleared; fetch_pc := RESET_PC. An rvalid arriving after reset with outstanding=0 is ignored.

## Timing
- Reset values: o_imem_req=0 (forced while rst), o_imem_addr=RESET_PC, o_instr_valid=0, o_instr=0, o_instr_pc=0.
- First request is asserted in the first cycle with rst=0.
- Latency from rvalid to o_instr_valid is 1 cycle (registered FIFO, no bypass). With a 1-cycle memory and no stalls, steady-state throughput is 1 instruction/cycle.
- The first request after a redirect is issued 1 cycle after the i_redirect cycle, at the new PC.
- o_instr/o_instr_pc are held stable while valid && !ready.

## Configuration
- CORE_IF_JAL_PREDECODE_EN defined:
  - Each non-discarded word pushed to the FIFO with opcode 7'b1101111 triggers an internal redirect in that same cycle to tag + J-immediate (sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - The JAL itself is enqueued. All younger outstanding reads are discarded, and no younger words are already in the FIFO.
  - No request is issued that cycle.
  - An external i_redirect in the same cycle takes priority.
- Undefined: no predecode; JAL is fetched through sequentially until an external redirect arrives.

## Test plan
- Reset release, 1-cycle memory, gnt=1, ready=1 → requests at 0x0, 0x4, 0x8…; o_instr_valid first high 2 cycles after the first request, with o_instr_pc 0x0, 0x4 in order.
- ready=0 for 10 cycles → at most FIFO_DEPTH reads are outstanding or buffered; req drops to 0; o_instr held stable; after ready=1, no instruction is lost or duplicated.
- Two reads outstanding, i_redirect with pc 0x100 → both late rvalids are dropped; the next request is at 0x100 one cycle later; the first delivered o_instr_pc is 0x100.
- i_redirect_pc=0x203 → fetch restarts at 0x200. fetch_pc at 0xFFFF_FFFC → the next request is at 0x0000_0000.
- rst asserted with two reads outstanding → outputs return to reset values next cycle; stale rvalids are ignored; fetch restarts at RESET_PC.
- With CORE_IF_JAL_PREDECODE_EN: word 0x0100006F (jal x0, +16) at PC 0x0 → JAL delivered with pc 0x0; the word fetched from 0x4 is dropped; the next delivered pc is 0x10.

Source files
------------

// File: rtl/core_if_stage.sv
// core_if_stage: instruction fetch stage of the RV32I core.
//
// This stage holds the fetch PC and issues word reads to instruction memory
// over a req/gnt/rvalid port. Responses come back in order. Each response is
// paired with its PC from a tag queue and buffered in an in-order FIFO. The
// FIFO head is presented to decode over a valid/ready handshake. A redirect
// flushes the FIFO and marks every read still in flight to be discarded.
//
// Parameters:
//   RESET_PC    first fetch address after reset (word aligned)
//   FIFO_DEPTH  instruction buffer entries (power of two, >= 2); this is also
//               the limit on reads that are outstanding or buffered
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   o_imem_req        read request (credit based, low during rst/redirect)
//   o_imem_addr       read address (the fetch PC)
//   i_imem_gnt        request accepted this cycle
//   i_imem_rvalid     read data valid (in order, >= 1 cycle after grant)
//   i_imem_rdata      read data
//   i_redirect        flush and restart fetch at i_redirect_pc
//   i_redirect_pc     new fetch PC; bits [1:0] are ignored
//   o_instr_valid     o_instr / o_instr_pc are valid
//   i_instr_ready     decode accepts the head entry
//   o_instr           instruction word at the FIFO head
//   o_instr_pc        PC of o_instr
//
// Optional feature macro: CORE_IF_JAL_PREDECODE_EN
//   When defined, a JAL word entering the FIFO redirects fetch to its target
//   in the same cycle. Younger in-flight reads are discarded.

module core_if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      fetch_pc;

    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [31:0]      fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0] fifo_rd_ptr;
    logic [PTR_W-1:0] fifo_wr_ptr;
    logic [CNT_W-1:0] fifo_count;

    logic [31:0]      tag_pc [FIFO_DEPTH];
    logic [PTR_W-1:0] tag_rd_ptr;
    logic [PTR_W-1:0] tag_wr_ptr;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;

    logic             issue;
    logic             resp_accept;
    logic             resp_drop;
    logic             push;
    logic             pop;
    logic             jal_redirect;
    logic [31:0]      jal_target;
    logic [31:0]      resp_tag;
    logic [31:0]      redirect_pc_aligned;
    logic [CNT_W:0]   credit_used;

    // A response with nothing outstanding is a stale one from before reset.
    assign resp_accept = i_imem_rvalid && (outstanding != '0);
    assign resp_drop   = resp_accept && (discard != '0);
    assign push        = resp_accept && (discard == '0) && !i_redirect;
    assign pop         = o_instr_valid && i_instr_ready;
    assign resp_tag    = tag_pc[tag_rd_ptr];

    assign redirect_pc_aligned = i_redirect_pc & ~32'h0000_0003;

`ifdef CORE_IF_JAL_PREDECODE_EN
    logic [31:0] jal_imm;
    assign jal_imm = {{11{i_imem_rdata[31]}}, i_imem_rdata[31], i_imem_rdata[19:12],
                      i_imem_rdata[20], i_imem_rdata[30:21], 1'b0};
    // Only words actually entering the FIFO can redirect; push already
    // excludes discarded data and gives an external redirect priority.
    assign jal_redirect = push && (i_imem_rdata[6:0] == 7'b1101111);
    assign jal_target   = resp_tag + jal_imm;
`else
    assign jal_redirect = 1'b0;
    assign jal_target   = '0;
`endif

    // Buffered entries and in-flight reads share the same credit pool, so a
    // response always finds room in the FIFO.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign o_imem_req  = !rst && !i_redirect && !jal_redirect && (credit_used < DEPTH_LIM);
    assign o_imem_addr = fetch_pc;
    assign issue       = o_imem_req && i_imem_gnt;

    assign o_instr_valid = (fifo_count != '0);
    assign o_instr       = o_instr_valid ? fifo_instr[fifo_rd_ptr] : '0;
    assign o_instr_pc    = o_instr_valid ? fifo_pc[fifo_rd_ptr]    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            fifo_rd_ptr <= '0;
            fifo_wr_ptr <= '0;
            fifo_count  <= '0;
            tag_rd_ptr  <= '0;
            tag_wr_ptr  <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (i_redirect) begin
                fetch_pc <= redirect_pc_aligned;
            end else if (jal_redirect) begin
                fetch_pc <= jal_target;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            // Discarded reads keep their tag slots. They pop in order as their
            // responses arrive, so the tag queue never needs flushing.
            if (issue) begin
                tag_wr_ptr <= tag_wr_ptr + PTR_W'(1);
            end
            if (resp_accept) begin
                tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
            end
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(resp_accept);

            // No issue can happen in a redirect cycle, so every read left in
            // flight after this edge must be dropped.
            if (i_redirect || jal_redirect) begin
                discard <= outstanding - CNT_W'(resp_accept);
            end else if (resp_drop) begin
                discard <= discard - CNT_W'(1);
            end

            if (i_redirect) begin
                fifo_rd_ptr <= '0;
                fifo_wr_ptr <= '0;
                fifo_count  <= '0;
            end else begin
                if (push) begin
                    fifo_wr_ptr <= fifo_wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    fifo_rd_ptr <= fifo_rd_ptr + PTR_W'(1);
                end
                fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            tag_pc[tag_wr_ptr] <= fetch_pc;
        end
        if (push) begin
            fifo_instr[fifo_wr_ptr] <= i_imem_rdata;
            fifo_pc[fifo_wr_ptr]    <= resp_tag;
        end
    end

endmodule

// File: tb/tb_core_if_stage.sv
// Testbench for core_if_stage: directed scenarios against a 1-cycle memory
// model that can hold responses back. Delivered instructions are compared
// against an expected PC stream kept by the bench.
`timescale 1ns/1ps

module tb_core_if_stage;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;

    always #5 clk = ~clk;

    core_if_stage #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc)
    );

    int          n_cmp = 0;
    int          n_err = 0;

    logic        mem_hold;
    logic        jal_mode;
    logic        chk_issue;
    logic [31:0] pend [$];
    logic [31:0] deliv_pcs [$];
    logic [31:0] expect_pc;
    logic [31:0] exp_issue;
    int unsigned n_issued;
    int unsigned n_deliv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Every word is an addi-class word tagged with its address, except that
    // address 0 holds "jal x0, +16" once jal_mode is set.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jal_mode && a == 32'h0) return 32'h0100_006F;
        return {a[24:0], 7'b0010011};
    endfunction

    task automatic tick();
        logic        issued;
        logic [31:0] iaddr;
        logic [31:0] w;
        #1;
        issued = o_imem_req && i_imem_gnt;
        iaddr  = o_imem_addr;
        if (issued) begin
            n_issued++;
            if (chk_issue) begin
                check("issue_addr", iaddr, exp_issue);
                exp_issue = exp_issue + 32'd4;
            end
            pend.push_back(iaddr);
        end
        if (o_instr_valid && i_instr_ready) begin
            n_deliv++;
            deliv_pcs.push_back(o_instr_pc);
            w = mem_word(expect_pc);
            check("deliv_pc", o_instr_pc, expect_pc);
            check("deliv_instr", o_instr, w);
`ifdef CORE_IF_JAL_PREDECODE_EN
            if (w == 32'h0100_006F) expect_pc = expect_pc + 32'd16;
            else expect_pc = expect_pc + 32'd4;
`else
            expect_pc = expect_pc + 32'd4;
`endif
        end
        if (i_redirect) begin
            expect_pc = i_redirect_pc & 32'hFFFF_FFFC;
            exp_issue = i_redirect_pc & 32'hFFFF_FFFC;
        end
        if (rst) begin
            expect_pc = RESET_PC;
            exp_issue = RESET_PC;
        end
        @(posedge clk);
        #1;
        if (!mem_hold && pend.size() > 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(pend.pop_front());
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic wait_pend2(input string tag);
        for (int i = 0; i < 20 && pend.size() != 2; i++) tick();
        check(tag, 32'(pend.size()), 32'd2);
    endtask

    initial begin
        rst = 1'b1; i_imem_gnt = 1'b1; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
        i_redirect = 1'b0; i_redirect_pc = '0; i_instr_ready = 1'b1;
        mem_hold = 1'b0; jal_mode = 1'b0; chk_issue = 1'b1;
        expect_pc = RESET_PC; exp_issue = RESET_PC; n_issued = 0; n_deliv = 0;

        // Reset state
        repeat (3) tick();
        check("rst_req", 32'(o_imem_req), 32'd0);
        check("rst_addr", o_imem_addr, RESET_PC);
        check("rst_valid", 32'(o_instr_valid), 32'd0);
        check("rst_instr", o_instr, 32'd0);
        check("rst_pc", o_instr_pc, 32'd0);

        // First request in the first cycle out of reset; data two cycles later
        rst = 1'b0;
        #1;
        check("first_req", 32'(o_imem_req), 32'd1);
        check("first_addr", o_imem_addr, 32'h0);
        tick();
        check("lat1_valid", 32'(o_instr_valid), 32'd0);
        tick();
        check("lat2_valid", 32'(o_instr_valid), 32'd1);
        check("lat2_pc", o_instr_pc, 32'h0);
        check("lat2_instr", o_instr, 32'h0000_0013);
        repeat (20) tick();
        check("stream_progress", 32'(n_deliv >= 10), 32'd1);

        // Decode stall: buffer fills to the credit limit and the head holds
        i_instr_ready = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stall_valid", 32'(o_instr_valid), 32'd1);
            check("stall_pc", o_instr_pc, expect_pc);
            check("stall_instr", o_instr, mem_word(expect_pc));
        end
        check("stall_req", 32'(o_imem_req), 32'd0);
        check("stall_inflight", 32'(n_issued - n_deliv), 32'(FIFO_DEPTH));
        i_instr_ready = 1'b1;
        repeat (12) tick();

        // Redirect with two reads in flight
        mem_hold = 1'b1;
        wait_pend2("redir_pend");
        check("redir_empty", 32'(o_instr_valid), 32'd0);
        i_redirect = 1'b1; i_redirect_pc = 32'h0000_0100;
        #1;
        check("redir_noreq", 32'(o_imem_req), 32'd0);
        tick();
        i_redirect = 1'b0; mem_hold = 1'b0;
        deliv_pcs.delete();
        check("redir_addr", o_imem_addr, 32'h0000_0100);
        repeat (12) tick();
        check("redir_first", (deliv_pcs.size() > 0) ? deliv_pcs[0] : 32'hFFFF_FFFF, 32'h0000_0100);

        // Unaligned redirect landing on a cycle with a response
        for (int i = 0; i < 10 && !i_imem_rvalid; i++) tick();
        check("align_rvalid", 32'(i_imem_rvalid), 32'd1);
        i_redirect = 1'b1; i_redirect_pc = 32'h0000_0203;
        tick();
        i_redirect = 1'b0;
        deliv_pcs.delete();
        check("align_addr", o_imem_addr, 32'h0000_0200);
        repeat (12) tick();
        check("align_first", (deliv_pcs.size() > 0) ? deliv_pcs[0] : 32'hFFFF_FFFF, 32'h0000_0200);

        // fetch_pc wraps from 0xFFFF_FFFC to 0
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFF8;
        tick();
        i_redirect = 1'b0;
        deliv_pcs.delete();
        repeat (14) tick();
        check("wrap_pc2", (deliv_pcs.size() > 2) ? deliv_pcs[2] : 32'hFFFF_FFFF, 32'h0000_0000);

        // Reset with two reads in flight; stale responses arrive afterwards
        mem_hold = 1'b1;
        wait_pend2("rst2_pend");
        rst = 1'b1; jal_mode = 1'b1;
`ifdef CORE_IF_JAL_PREDECODE_EN
        chk_issue = 1'b0;
`endif
        tick();
        check("rst2_req", 32'(o_imem_req), 32'd0);
        check("rst2_addr", o_imem_addr, RESET_PC);
        check("rst2_valid", 32'(o_instr_valid), 32'd0);
        check("rst2_instr", o_instr, 32'd0);
        check("rst2_pc", o_instr_pc, 32'd0);
        rst = 1'b0; i_imem_gnt = 1'b0; mem_hold = 1'b0;
        repeat (4) tick();
        check("stale_drained", 32'(pend.size()), 32'd0);
        check("stale_valid", 32'(o_instr_valid), 32'd0);
        check("stale_addr", o_imem_addr, RESET_PC);

        // Restart at RESET_PC with both 0x0 (a JAL) and 0x4 in flight
        i_imem_gnt = 1'b1; mem_hold = 1'b1;
        deliv_pcs.delete();
        wait_pend2("jal_pend");
        mem_hold = 1'b0;
        repeat (12) tick();
        check("jal_first", (deliv_pcs.size() > 0) ? deliv_pcs[0] : 32'hFFFF_FFFF, 32'h0000_0000);
`ifdef CORE_IF_JAL_PREDECODE_EN
        check("jal_second", (deliv_pcs.size() > 1) ? deliv_pcs[1] : 32'hFFFF_FFFF, 32'h0000_0010);
`else
        check("jal_second", (deliv_pcs.size() > 1) ? deliv_pcs[1] : 32'hFFFF_FFFF, 32'h0000_0004);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
